// File: rtl/serial_adder_module_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state
// encodings and the carry-majority helper used by the full-adder cell.
package serial_adder_module_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Carry out of a full adder: true when at least two inputs are set.
  function automatic logic majority(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/serial_adder_module_fa.sv
// Single-bit combinational full adder; the only arithmetic cell of the
// serial adder. The carry is a majority vote of the three inputs.
module full_adder_cell_module
  import serial_adder_module_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum and carry of one bit position.
  always_comb begin
    s  = x ^ y ^ ci;
    co = majority(x, y, ci);
  end

endmodule

// File: rtl/serial_adder_module.sv
// Bit-serial add/subtract unit. Operands are captured on an accepted start,
// then consumed LSB-first through one full-adder cell with a carry flop.
// Subtraction is a + ~b + 1. Results are published only when the last bit
// has been produced, so sum/cout/ovf never expose partial values.
module serial_adder_module
  import serial_adder_module_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  // Bit index of the last bit, and of the bit whose carry-out feeds the MSB.
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_MSB  = CW'(WIDTH - 2);

  logic [1:0]       state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] shreg;
  logic             carry;
  logic             c_msb;
  logic [CW-1:0]    cnt;
  logic             s_bit;
  logic             co_bit;

  full_adder_cell_module u_fa (
    .x  (opa[0]),
    .y  (opb[0]),
    .ci (carry),
    .s  (s_bit),
    .co (co_bit)
  );

  // Handshake outputs decode directly from the state register.
  always_comb begin
    busy = (state == ST_RUN);
    done = (state == ST_DONE);
  end

  // FSM, operand/result shift registers, carry tracking and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      opa   <= '0;
      opb   <= '0;
      shreg <= '0;
      carry <= 1'b0;
      c_msb <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          shreg <= {s_bit, shreg[WIDTH-1:1]};
          carry <= co_bit;
          if (cnt == CNT_MSB) begin
            c_msb <= co_bit;
          end
          if (cnt == CNT_LAST) begin
            // Last bit: publish the complete result including this bit.
            sum   <= {s_bit, shreg[WIDTH-1:1]};
            cout  <= co_bit;
            ovf   <= c_msb ^ co_bit;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_module.sv
// Bench for serial_adder_module: directed cases at WIDTH=8, random cases
// against an arithmetic reference, and an exhaustive sweep at WIDTH=4.
module tb_serial_adder_module;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  logic       start4 = 1'b0, sub4 = 1'b0, cin4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, cout4, ovf4;
  logic [3:0] sum4;

  int checks = 0;
  int errors = 0;

  logic [31:0] got_sum;
  logic        got_cout, got_ovf, sum_moved;

  always #5 clk = ~clk;

  serial_adder_module #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .cin(cin8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .sum(sum8),
    .cout(cout8), .ovf(ovf8)
  );

  serial_adder_module #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub4), .cin(cin4),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .sum(sum4),
    .cout(cout4), .ovf(ovf4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: w-bit two's-complement add/subtract. Returns {ovf, cout, sum}.
  function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic s, input logic c);
    longint unsigned mask = (64'd1 << w) - 1;
    longint unsigned am   = {32'd0, a} & mask;
    longint unsigned bm   = (s ? ~{32'd0, b} : {32'd0, b}) & mask;
    longint unsigned r    = am + bm + ((s || c) ? 64'd1 : 64'd0);
    longint unsigned rs   = r & mask;
    logic sa = am[w-1];
    logic sb = bm[w-1];
    logic sr = rs[w-1];
    logic co = r[w];
    logic ov = (sa == sb) && (sr != sa);
    return {ov, co, rs[31:0]};
  endfunction

  function automatic logic [31:0] cur_sum(input int w);
    return (w == 8) ? {24'd0, sum8} : {28'd0, sum4};
  endfunction

  task automatic launch(input int w, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic c);
    if (w == 8) begin
      a8 = a[7:0]; b8 = b[7:0]; sub8 = s; cin8 = c; start8 = 1'b1;
    end else begin
      a4 = a[3:0]; b4 = b[3:0]; sub4 = s; cin4 = c; start4 = 1'b1;
    end
  endtask

  // Counts edges from start assertion until done is seen (bounded).
  task automatic wait_done(input int w, output int lat);
    logic [31:0] prev;
    logic        d;
    prev      = cur_sum(w);
    sum_moved = 1'b0;
    lat       = 0;
    d         = 1'b0;
    while (!d && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (w == 8) start8 = 1'b0; else start4 = 1'b0;
      d = (w == 8) ? done8 : done4;
      if (!d && cur_sum(w) !== prev) sum_moved = 1'b1;
    end
    got_sum  = cur_sum(w);
    got_cout = (w == 8) ? cout8 : cout4;
    got_ovf  = (w == 8) ? ovf8 : ovf4;
  endtask

  task automatic check_model(input string tag, input int w, input logic [31:0] a,
                             input logic [31:0] b, input logic s, input logic c, input int lat);
    logic [33:0] e;
    e = model(w, a, b, s, c);
    chk({tag, "_res"}, {lat[7:0], got_ovf, got_cout, got_sum},
        {8'(w + 1), e[33], e[32], e[31:0]});
  endtask

  initial begin
    int          lat;
    int          lat2;
    int          pulses;
    logic [31:0] ra, rb;
    logic        rs, rc;
    logic [31:0] s1;
    logic        c1, o1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset8", {busy8, done8, sum8, cout8, ovf8}, '0);
    chk("reset4", {busy4, done4, sum4, cout4, ovf4}, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1. 5A + 33
    launch(8, 32'h5A, 32'h33, 1'b0, 1'b0);
    wait_done(8, lat);
    chk("t1_lat", lat, 9);
    chk("t1_res", {got_cout, got_ovf, got_sum}, {1'b0, 1'b1, 32'h8D});
    @(posedge clk); #1;
    chk("t1_pulse", {done8, busy8, sum8}, {1'b0, 1'b0, 8'h8D});

    // 2. FF + 01, 7F + 00 + cin
    launch(8, 32'hFF, 32'h01, 1'b0, 1'b0);
    wait_done(8, lat);
    chk("t2a_lat", lat, 9);
    chk("t2a_hold", sum_moved, 0);
    chk("t2a_res", {got_cout, got_ovf, got_sum}, {1'b1, 1'b0, 32'h00});
    launch(8, 32'h7F, 32'h00, 1'b0, 1'b1);
    wait_done(8, lat);
    chk("t2b_lat", lat, 9);
    chk("t2b_res", {got_cout, got_ovf, got_sum}, {1'b0, 1'b1, 32'h80});

    // 3. Subtraction; cin must be ignored
    launch(8, 32'h10, 32'h20, 1'b1, 1'b1);
    wait_done(8, lat);
    chk("t3a_hold", sum_moved, 0);
    chk("t3a_res", {got_cout, got_ovf, got_sum}, {1'b0, 1'b0, 32'hF0});
    launch(8, 32'h80, 32'h01, 1'b1, 1'b0);
    wait_done(8, lat);
    chk("t3b_lat", lat, 9);
    chk("t3b_res", {got_cout, got_ovf, got_sum}, {1'b1, 1'b1, 32'h7F});
    @(posedge clk); #1;

    // 4a. start held through RUN with changing operands
    launch(8, 32'h5A, 32'h33, 1'b0, 1'b0);
    lat = 0;
    while (!done8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom); cin8 = 1'($urandom);
      start8 = (lat < 8);
    end
    start8 = 1'b0;
    chk("t4a_lat", lat, 9);
    chk("t4a_res", {cout8, ovf8, sum8}, {1'b0, 1'b1, 8'h8D});
    @(posedge clk); #1;

    // 4b. back-to-back: second start issued in the DONE cycle
    launch(8, 32'hFF, 32'h01, 1'b0, 1'b0);
    wait_done(8, lat);
    s1 = got_sum; c1 = got_cout; o1 = got_ovf;
    launch(8, 32'h80, 32'h01, 1'b1, 1'b0);
    wait_done(8, lat2);
    chk("t4b_first", {lat[7:0], c1, o1, s1}, {8'd9, 1'b1, 1'b0, 32'h00});
    chk("t4b_gap", lat2, 9);
    chk("t4b_second", {got_cout, got_ovf, got_sum}, {1'b1, 1'b1, 32'h7F});

    // Random operands at WIDTH=8
    for (int i = 0; i < 40; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom); rc = 1'($urandom);
      launch(8, ra, rb, rs, rc);
      wait_done(8, lat);
      check_model("rand8", 8, ra, rb, rs, rc, lat);
    end
    @(posedge clk); #1;

    // 5. reset in the middle of RUN discards everything
    launch(8, 32'h5A, 32'h33, 1'b0, 1'b0);
    repeat (4) begin
      @(posedge clk); #1;
      start8 = 1'b0;
    end
    chk("t5_prerst", {busy8, sum8 != 8'h00}, {1'b1, 1'b1});
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_rst", {busy8, done8, sum8, cout8, ovf8}, '0);
    rst = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done8 || busy8) pulses++;
    end
    chk("t5_nodone", pulses, 0);

    // 6. exhaustive sweep at WIDTH=4
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int k = 0; k < 4; k++) begin
          rs = k[1];
          rc = k[0];
          launch(4, 32'(ia), 32'(ib), rs, rc);
          wait_done(4, lat);
          check_model("exh4", 4, 32'(ia), 32'(ib), rs, rc, lat);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
